// File: rtl/numsend.sv
// numsend: sends a 32-bit value as ASCII hex, MSD first, leading zeros suppressed.
// Define NUMSEND_CRLF_EN to append CR LF after the last digit.
module numsend #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned LOWER  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        txready,
  output logic [7:0]  txdata,
  output logic        txclk,
  output logic        busy,
  output logic        done
);

  localparam int unsigned VAL_W = 32;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned NIBS  = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WAITRDY, S_STROBE, S_GAP, S_FINISH
  } state_t;

`ifdef NUMSEND_CRLF_EN
  typedef enum logic [1:0] {PH_DIGIT, PH_CR, PH_LF} phase_t;
  phase_t r_phase, w_phase_nxt;
`endif

  state_t             r_state, w_state_nxt;
  logic [VAL_W-1:0]   r_sreg, w_sreg_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [VAL_W-1:0]   w_masked;
  logic [7:0]         w_char;
  logic [7:0]         r_txdata;
  logic               r_txclk, r_busy, r_done;

  function automatic logic [VAL_W-1:0] digit_mask();
    logic [VAL_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NIBS; i++)
      if (i < DIGITS) m[4*i +: 4] = 4'hF;
    return m;
  endfunction

  // Highest nonzero nibble, 0 when the value is all zero.
  function automatic logic [IDX_W-1:0] top_idx(input logic [VAL_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NIBS; i++)
      if (v[4*i +: 4] != 4'h0) idx = IDX_W'(i);
    return idx;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return ((LOWER != 0) ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  assign w_masked = value & digit_mask();

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_idx_nxt   = r_idx;
`ifdef NUMSEND_CRLF_EN
    w_phase_nxt = r_phase;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sreg_nxt  = w_masked;
          w_idx_nxt   = top_idx(w_masked);
`ifdef NUMSEND_CRLF_EN
          w_phase_nxt = PH_DIGIT;
`endif
          w_state_nxt = S_WAITRDY;
        end
      end
      S_WAITRDY: if (txready) w_state_nxt = S_STROBE;
      S_STROBE:  w_state_nxt = S_GAP;
      S_GAP: begin
`ifdef NUMSEND_CRLF_EN
        w_state_nxt = S_WAITRDY;
        if (r_phase == PH_DIGIT && r_idx != '0) w_idx_nxt = r_idx - IDX_W'(1);
        else if (r_phase == PH_DIGIT)           w_phase_nxt = PH_CR;
        else if (r_phase == PH_CR)              w_phase_nxt = PH_LF;
        else                                    w_state_nxt = S_FINISH;
`else
        if (r_idx == '0) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_idx_nxt   = r_idx - IDX_W'(1);
          w_state_nxt = S_WAITRDY;
        end
`endif
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    // Byte presented for the upcoming WAITRDY/STROBE/GAP sequence.
    w_char = hex_ascii(w_sreg_nxt[{w_idx_nxt, 2'b00} +: 4]);
`ifdef NUMSEND_CRLF_EN
    if (w_phase_nxt == PH_CR)      w_char = 8'h0D;
    else if (w_phase_nxt == PH_LF) w_char = 8'h0A;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sreg   <= '0;
      r_idx    <= '0;
      r_txdata <= '0;
      r_txclk  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef NUMSEND_CRLF_EN
      r_phase  <= PH_DIGIT;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_sreg   <= w_sreg_nxt;
      r_idx    <= w_idx_nxt;
      r_txclk  <= (r_state == S_STROBE);
      r_done   <= (r_state == S_FINISH);
      r_busy   <= (w_state_nxt != S_IDLE);
      if (w_state_nxt == S_WAITRDY) r_txdata <= w_char;
`ifdef NUMSEND_CRLF_EN
      r_phase  <= w_phase_nxt;
`endif
    end
  end

  assign txdata = r_txdata;
  assign txclk  = r_txclk;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_numsend.sv
// Self-checking bench for numsend: directed timing/stall/reset cases plus random values.
module tb_numsend;

  logic        clk = 1'b0;
  logic        rst;
  logic        txready;
  logic        a_start, b_start;
  logic [31:0] a_value, b_value;
  logic [7:0]  a_txdata, b_txdata;
  logic        a_txclk, b_txclk, a_busy, b_busy, a_done, b_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          c0;
  logic [7:0]  got_a[$], got_b[$], exp_q[$];
  int          cyc_a[$];
  int          done_a, done_b, done_cyc_a;
  logic        done_busy_a;

  numsend u_dut (
    .clk(clk), .rst(rst), .start(a_start), .value(a_value), .txready(txready),
    .txdata(a_txdata), .txclk(a_txclk), .busy(a_busy), .done(a_done)
  );

  numsend #(.DIGITS(4), .LOWER(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(b_start), .value(b_value), .txready(txready),
    .txdata(b_txdata), .txclk(b_txclk), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_txclk) begin
      got_a.push_back(a_txdata);
      cyc_a.push_back(cyc);
    end
    if (a_done) begin
      done_a      = done_a + 1;
      done_cyc_a  = cyc;
      done_busy_a = a_busy;
    end
    if (b_txclk) got_b.push_back(b_txdata);
    if (b_done) done_b = done_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: the characters a human would write for the number, no leading zeros.
  task automatic build_exp(input logic [31:0] v, input int digits, input bit lower);
    int hi;
    logic [3:0] n;
    exp_q.delete();
    hi = 0;
    for (int i = 0; i < digits; i++)
      if (((v >> (4 * i)) & 32'hF) != 0) hi = i;
    for (int i = hi; i >= 0; i--) begin
      n = 4'((v >> (4 * i)) & 32'hF);
      if (n < 10)    exp_q.push_back("0" + 8'(n));
      else if (lower) exp_q.push_back("a" + 8'(n) - 8'd10);
      else            exp_q.push_back("A" + 8'(n) - 8'd10);
    end
`ifdef NUMSEND_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic start_xfer(input int which, input logic [31:0] v);
    got_a.delete(); cyc_a.delete(); got_b.delete();
    done_a = 0; done_b = 0;
    c0 = cyc;
    if (which == 0) begin a_value = v; a_start = 1'b1; end
    else            begin b_value = v; b_start = 1'b1; end
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_done(input int which, input bit rnd);
    int dc;
    dc = 0;
    for (int i = 0; i < 3000 && dc == 0; i++) begin
      if (rnd) txready = ($urandom_range(0, 2) != 0);
      tick();
      dc = (which == 0) ? done_a : done_b;
    end
    txready = 1'b1;
    check("done_seen", 32'(dc > 0), 32'd1);
    repeat (4) tick();
    check("done_count", 32'((which == 0) ? done_a : done_b), 32'd1);
  endtask

  task automatic check_bytes(input int which);
    int n;
    n = (which == 0) ? got_a.size() : got_b.size();
    check("nbytes", 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check("byte", 32'((which == 0) ? got_a[i] : got_b[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [31:0] v;
    bit stable;
    rst = 1'b1; txready = 1'b1;
    a_start = 1'b0; b_start = 1'b0; a_value = '0; b_value = '0;
    done_a = 0; done_b = 0; done_cyc_a = 0; done_busy_a = 1'b1;
    repeat (3) tick();
    check("rst_txdata", 32'(a_txdata), 32'h0);
    check("rst_txclk", 32'(a_txclk), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_done", 32'(a_done), 32'h0);

    // start together with reset is dropped
    a_start = 1'b1; a_value = 32'h55;
    tick();
    rst = 1'b0; a_start = 1'b0;
    tick();
    check("start_during_rst_busy", 32'(a_busy), 32'h0);

    // nominal transfer with exact cycle positions
    start_xfer(0, 32'h0000_1A3F);
    check("busy_after_start", 32'(a_busy), 32'h1);
    wait_done(0, 1'b0);
    build_exp(32'h0000_1A3F, 8, 1'b0);
    check_bytes(0);
    for (int i = 0; i < cyc_a.size(); i++)
      check("strobe_cycle", 32'(cyc_a[i] - c0), 32'(3 + 3 * i));
    check("done_cycle", 32'(done_cyc_a - c0), 32'(2 + 3 * exp_q.size()));
    check("busy_at_done", 32'(done_busy_a), 32'h0);

    // zero and all-ones
    start_xfer(0, 32'h0);
    wait_done(0, 1'b0);
    build_exp(32'h0, 8, 1'b0);
    check_bytes(0);
    start_xfer(0, 32'hFFFF_FFFF);
    wait_done(0, 1'b0);
    build_exp(32'hFFFF_FFFF, 8, 1'b0);
    check_bytes(0);

    // txready stall: no strobe, txdata stable
    txready = 1'b0;
    start_xfer(0, 32'h42);
    stable = 1'b1;
    repeat (10) begin
      if (a_txdata !== 8'h34) stable = 1'b0;
      tick();
    end
    check("stall_no_txclk", 32'(got_a.size()), 32'd0);
    check("stall_txdata_stable", 32'(stable), 32'd1);
    txready = 1'b1;
    wait_done(0, 1'b0);
    build_exp(32'h42, 8, 1'b0);
    check_bytes(0);

    // value change and start re-pulse while busy are ignored
    start_xfer(0, 32'h12);
    repeat (3) tick();
    a_value = 32'h99; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done(0, 1'b0);
    build_exp(32'h12, 8, 1'b0);
    check_bytes(0);

    // reset after the second strobe aborts the transfer
    start_xfer(0, 32'h1234);
    for (int i = 0; i < 100 && got_a.size() < 2; i++) tick();
    check("abort_two_strobes", 32'(got_a.size()), 32'd2);
    rst = 1'b1;
    tick();
    check("abort_txclk", 32'(a_txclk), 32'h0);
    check("abort_busy", 32'(a_busy), 32'h0);
    check("abort_txdata", 32'(a_txdata), 32'h0);
    rst = 1'b0;
    repeat (20) tick();
    check("abort_no_done", 32'(done_a), 32'd0);
    check("abort_no_more_bytes", 32'(got_a.size()), 32'd2);
    start_xfer(0, 32'h7);
    wait_done(0, 1'b0);
    build_exp(32'h7, 8, 1'b0);
    check_bytes(0);

    // DIGITS=4, LOWER=1 instance
    start_xfer(1, 32'hABCD_0012);
    wait_done(1, 1'b0);
    build_exp(32'hABCD_0012, 4, 1'b1);
    check_bytes(1);
    start_xfer(1, 32'hFFFF_FFFF);
    wait_done(1, 1'b0);
    build_exp(32'hFFFF_FFFF, 4, 1'b1);
    check_bytes(1);

    // random values with random leading-zero counts and txready jitter
    for (int t = 0; t < 24; t++) begin
      v = $urandom() >> $urandom_range(0, 31);
      start_xfer(t % 2, v);
      wait_done(t % 2, 1'b1);
      if (t % 2 == 0) build_exp(v, 8, 1'b0);
      else            build_exp(v, 4, 1'b1);
      check_bytes(t % 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
